// File: rtl/wb_stream_demux.sv
// wb_stream_demux: registered 1-to-NOUT stream demultiplexer. It has a
// valid/ready handshake and one holding register.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_data/in_sel : the input stream
//   out_valid[NOUT] (one-hot), out_ready[NOUT], out_data[NOUT*WIDTH]
//   sel_err : one-cycle pulse when an out-of-range select is dropped
// Optional: define WB_DEMUX_STATS_EN to add the 16-bit saturating counters
//   xfer_cnt (drains) and drop_cnt (dropped out-of-range words).
module wb_stream_demux #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic                  sel_err
`ifdef WB_DEMUX_STATS_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  hdata_q, hdata_d;
    logic [SELW-1:0]   hsel_q, hsel_d;
    logic              sel_err_q, sel_err_d;

    logic rdy_sel;
    logic drain;
    logic in_range;
    logic acc;

    // Only the ready of the lane currently holding the word matters.
    always_comb begin
        rdy_sel = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            if (hsel_q == SELW'(k)) rdy_sel = out_ready[k];
        end
    end

    assign drain    = (state_q == FULL) && rdy_sel;
    assign in_ready = !rst && ((state_q == EMPTY) || drain);
    assign in_range = 32'(in_sel) < 32'(NOUT);
    assign acc      = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        hdata_d   = hdata_q;
        hsel_d    = hsel_q;
        sel_err_d = acc && !in_range;
        if (acc && in_range) begin
            state_d = FULL;
            hdata_d = in_data;
            hsel_d  = in_sel;
        end else if (drain) begin
            // A dropped word arriving on a drain cycle also empties the slot.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            hdata_q   <= '0;
            hsel_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdata_q   <= hdata_d;
            hsel_q    <= hsel_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NOUT; k++) begin
            out_valid[k] = (state_q == FULL) && (hsel_q == SELW'(k));
        end
    end

    assign out_data = {NOUT{hdata_q}};
    assign sel_err  = sel_err_q;

`ifdef WB_DEMUX_STATS_EN
    logic [15:0] xfer_q, xfer_d;
    logic [15:0] drop_q, drop_d;

    always_comb begin
        xfer_d = xfer_q;
        drop_d = drop_q;
        if (drain && xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
        if (sel_err_d && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q <= '0;
            drop_q <= '0;
        end else begin
            xfer_q <= xfer_d;
            drop_q <= drop_d;
        end
    end

    assign xfer_cnt = xfer_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_wb_stream_demux.sv
// Self-checking bench for wb_stream_demux: vector table, hand sequences
// and a scoreboard on the NOUT=4 instance; NOUT=3 instance for bad selects.
module tb_wb_stream_demux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [1:0]   in_sel = '0;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = '0;
    logic [127:0] out_data;
    logic         sel_err;

    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [31:0]  b_data = '0;
    logic [1:0]   b_sel = '0;
    logic [2:0]   b_ovalid;
    logic [2:0]   b_oready = '0;
    logic [95:0]  b_odata;
    logic         b_err;

`ifdef WB_DEMUX_STATS_EN
    logic [15:0]  xfer_cnt, drop_cnt;
    logic [15:0]  b_xfer, b_drop;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_stream_demux #(.WIDTH(32), .NOUT(4), .SELW(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sel_err(sel_err)
`ifdef WB_DEMUX_STATS_EN
        , .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
`endif
    );

    wb_stream_demux #(.WIDTH(32), .NOUT(3), .SELW(2)) u_bad (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_sel(b_sel),
        .out_valid(b_ovalid), .out_ready(b_oready),
        .out_data(b_odata), .sel_err(b_err)
`ifdef WB_DEMUX_STATS_EN
        , .xfer_cnt(b_xfer), .drop_cnt(b_drop)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: {lane, data} pushed on accept, popped on drain.
    typedef struct packed {
        logic [1:0]  lane;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!$onehot0(out_valid)) begin
                bad++;
                $display("FAIL onehot: out_valid=%b", out_valid);
            end
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: lane %0d data %h unexpected",
                                 k, out_data[k*32 +: 32]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_lane", 32'(k), 32'(e.lane));
                        check("sb_data", out_data[k*32 +: 32], e.data);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back({in_sel, in_data});
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  exp_ov;
    } vec_t;
    vec_t vecs[8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].sel    = 2'(i % 4);
            vecs[i].data   = 32'(i + 1);
            vecs[i].exp_ov = 4'b0001 << (i % 4);
        end

        // reset state
        #2;
        check("rst_ov", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_err", 32'(sel_err), 32'h0);
        check("rst_data", out_data[31:0], 32'h0);
        step();
        step();
        rst = 1'b0;
        out_ready = 4'hF;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'h1);
        step();

        // single route
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_ov", 32'(out_valid), 32'h2);
        check("single_data", out_data[63:32], 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("single_empty", 32'(out_valid), 32'h0);
        check("single_ready", 32'(in_ready), 32'h1);
        step();

        // back-pressure on lane 3
        out_ready = 4'b0111;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 32'hA3A3A3A3;
        step();
        in_sel  = 2'd0;
        in_data = 32'hB0B0B0B0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(in_ready), 32'h0);
            check("bp_ov", 32'(out_valid), 32'h8);
            check("bp_data", out_data[127:96], 32'hA3A3A3A3);
            step();
        end
        out_ready = 4'hF;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_ov", 32'(out_valid), 32'h1);
        check("bp_next_data", out_data[31:0], 32'hB0B0B0B0);
        step();

        // streaming table
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_sel   = vecs[i].sel;
                in_data  = vecs[i].data;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("stream_ready", 32'(in_ready), 32'h1);
            if (i > 0) begin
                check("stream_ov", 32'(out_valid), 32'(vecs[i-1].exp_ov));
                check("stream_data", out_data[vecs[i-1].sel*32 +: 32],
                      vecs[i-1].data);
            end
            step();
        end
        @(negedge clk);
        check("stream_empty", 32'(out_valid), 32'h0);
        step();

        // reset mid-transfer with word on lane 2
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hCCCCCCCC;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_ov", 32'(out_valid), 32'h4);
        step();
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_ov", 32'(out_valid), 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        check("mid_rst_err", 32'(sel_err), 32'h0);
        step();
        rst = 1'b0;
        out_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("after_rst_ready", 32'(in_ready), 32'h1);
            check("after_rst_ov", 32'(out_valid), 32'h0);
            step();
        end

        // bad select on the NOUT=3 instance
        b_oready = 3'b111;
        b_valid  = 1'b1;
        b_sel    = 2'd3;
        b_data   = 32'h55;
        @(negedge clk);
        check("bad_accept", 32'(b_ready), 32'h1);
        step();
        b_valid = 1'b0;
        @(negedge clk);
        check("bad_err", 32'(b_err), 32'h1);
        check("bad_ov", 32'(b_ovalid), 32'h0);
`ifdef WB_DEMUX_STATS_EN
        check("bad_drop_cnt", 32'(b_drop), 32'h1);
`endif
        step();
        @(negedge clk);
        check("bad_err_gone", 32'(b_err), 32'h0);
        check("bad_ov2", 32'(b_ovalid), 32'h0);
        step();

        // bad select while FULL and draining -> EMPTY
        b_oready = 3'b000;
        b_valid  = 1'b1;
        b_sel    = 2'd0;
        b_data   = 32'h77;
        step();
        b_sel = 2'd3;
        b_data = 32'h99;
        @(negedge clk);
        check("bad_full_ready", 32'(b_ready), 32'h0);
        check("bad_full_ov", 32'(b_ovalid), 32'h1);
        step();
        b_oready = 3'b001;
        @(negedge clk);
        check("bad_drain_ready", 32'(b_ready), 32'h1);
        step();
        b_valid = 1'b0;
        @(negedge clk);
        check("bad_drain_err", 32'(b_err), 32'h1);
        check("bad_drain_ov", 32'(b_ovalid), 32'h0);
        step();

`ifdef WB_DEMUX_STATS_EN
        // saturate the drain counter
        rst = 1'b1;
        #1;
        sb.delete();
        step();
        rst = 1'b0;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int c = 0; c < 65538; c++) begin
            in_data = 32'(c);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check("sat_xfer", 32'(xfer_cnt), 32'hFFFF);
        check("sat_drop", 32'(drop_cnt), 32'h0);
        step();
`endif

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
